// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the pipelined ID stage:
// field positions, opcode enums, decoded control bundle.
package id_pkg;

    localparam int FT_HI  = 31;
    localparam int FT_LO  = 30;
    localparam int FC_HI  = 29;
    localparam int FC_LO  = 28;
    localparam int RD_HI  = 27;
    localparam int RD_LO  = 24;
    localparam int RA_HI  = 23;
    localparam int RA_LO  = 20;
    localparam int RB_HI  = 19;
    localparam int RB_LO  = 16;
    localparam int IMMSEL = 15;

    typedef enum logic [1:0] {
        FT_ALU    = 2'b00,
        FT_MEM    = 2'b01,
        FT_BRANCH = 2'b10,
        FT_CACHE  = 2'b11
    } funtype_e;

    typedef enum logic [1:0] {
        FC_0 = 2'b00,
        FC_1 = 2'b01,
        FC_2 = 2'b10,
        FC_3 = 2'b11
    } funcode_e;

    typedef struct packed {
        logic [3:0] rd;
        funtype_e   funtype;
        funcode_e   funcode;
        logic       sel_wb;
        logic       sel_memrd;
        logic       sel_memwr;
        logic       sel_cachewr;
        logic       sel_cachesh;
        logic       sel_branch;
    } decoded_t;

    // R0 and indices beyond the implemented file are not real registers.
    function automatic logic reg_ok(input logic [3:0] idx, input int nreg);
        return (idx != 4'd0) && (int'(idx) < nreg);
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Fetch/writeback/execute side signals of the ID stage.
// master: fetch+WB+EX side driver; slave: the ID stage.
interface id_stage_pipe_if #(
    parameter int BUS = 32
);
    logic [31:0]    instruction;
    logic [BUS-1:0] PCi;
    logic           in_valid;
    logic           in_ready;
    logic [BUS-1:0] WBd;
    logic [3:0]     RDwb;
    logic           WE;
    logic           flush;
    logic           out_ready;
    logic           out_valid;
    logic [BUS-1:0] OPA;
    logic [BUS-1:0] OPB;
    logic [BUS-1:0] STR_DATA;
    logic [BUS-1:0] PCo;
    logic [BUS-1:0] RKo;
    logic [3:0]     RDo;
    logic [1:0]     FUNTYPE;
    logic [1:0]     FUNCODE;
    logic           selWB;
    logic           selMEMRD;
    logic           selMEMWR;
    logic           selCACHEWR;
    logic           selCACHESH;
    logic           selBRANCH;

    modport master (
        output instruction, PCi, in_valid,
        output WBd, RDwb, WE, flush, out_ready,
        input  in_ready, out_valid,
        input  OPA, OPB, STR_DATA, PCo, RKo, RDo,
        input  FUNTYPE, FUNCODE,
        input  selWB, selMEMRD, selMEMWR,
        input  selCACHEWR, selCACHESH, selBRANCH
    );

    modport slave (
        input  instruction, PCi, in_valid,
        input  WBd, RDwb, WE, flush, out_ready,
        output in_ready, out_valid,
        output OPA, OPB, STR_DATA, PCo, RKo, RDo,
        output FUNTYPE, FUNCODE,
        output selWB, selMEMRD, selMEMWR,
        output selCACHEWR, selCACHESH, selBRANCH
    );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// Register file: ports ra/rb/rs read (da/db/ds), we/wa/wd write.
// WB_BYPASS_EN: reads matching the write index return wd.
module id_regfile
    import id_pkg::*;
#(
    parameter int BUS  = 32,
    parameter int NREG = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     ra,
    input  logic [3:0]     rb,
    input  logic [3:0]     rs,
    output logic [BUS-1:0] da,
    output logic [BUS-1:0] db,
    output logic [BUS-1:0] ds,
    input  logic           we,
    input  logic [3:0]     wa,
    input  logic [BUS-1:0] wd
);

    logic [BUS-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && reg_ok(wa, NREG)) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [BUS-1:0] rd_port(input logic [3:0] idx);
        logic [BUS-1:0] v;
        v = '0;
        if (reg_ok(idx, NREG)) begin
            v = regs[idx];
`ifdef WB_BYPASS_EN
            if (we && wa == idx) begin
                v = wd;
            end
`endif
        end
        return v;
    endfunction

    always_comb da = rd_port(ra);
    always_comb db = rd_port(rb);
    always_comb ds = rd_port(rs);

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: regfile read, RAW scoreboard, ID/EX reg.
// Ports: clk, rst (sync, low), bus (slave). Option: WB_BYPASS_EN.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int BUS  = 32,
    parameter int NREG = 16,
    parameter int IMMW = 15
) (
    input logic           clk,
    input logic           rst,
    id_stage_pipe_if.slave bus
);

    logic [1:0]      ft;
    logic [1:0]      fc;
    logic [3:0]      rd;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic            immsel;
    logic [IMMW-1:0] imm;
    logic [BUS-1:0]  imm_sx;

    assign ft     = bus.instruction[FT_HI:FT_LO];
    assign fc     = bus.instruction[FC_HI:FC_LO];
    assign rd     = bus.instruction[RD_HI:RD_LO];
    assign ra     = bus.instruction[RA_HI:RA_LO];
    assign rb     = bus.instruction[RB_HI:RB_LO];
    assign immsel = bus.instruction[IMMSEL];
    assign imm    = bus.instruction[IMMW-1:0];
    assign imm_sx = {{(BUS-IMMW){imm[IMMW-1]}}, imm};

    decoded_t dec;
    logic     is_store;

    always_comb begin
        dec = '0;
        dec.rd = rd;
        dec.funtype = funtype_e'(ft);
        dec.funcode = funcode_e'(fc);
        unique case (1'b1)
            ft == FT_ALU: dec.sel_wb = 1'b1;
            ft == FT_MEM: begin
                dec.sel_memrd = (fc == FC_0);
                dec.sel_wb    = (fc == FC_0);
                dec.sel_memwr = (fc == FC_1);
            end
            ft == FT_BRANCH: dec.sel_branch = 1'b1;
            ft == FT_CACHE: begin
                dec.sel_cachewr = (fc == FC_0);
                dec.sel_cachesh = (fc == FC_1);
            end
            default: ;
        endcase
    end

    assign is_store = dec.sel_memwr;

    logic [BUS-1:0] rf_a;
    logic [BUS-1:0] rf_b;
    logic [BUS-1:0] rf_s;

    id_regfile #(
        .BUS  (BUS),
        .NREG (NREG)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra  (ra),
        .rb  (rb),
        .rs  (rd),
        .da  (rf_a),
        .db  (rf_b),
        .ds  (rf_s),
        .we  (bus.WE),
        .wa  (bus.RDwb),
        .wd  (bus.WBd)
    );

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_nxt;
    logic            hazard;
    logic            ready;
    logic            accept;
    logic            vld;
    decoded_t        held;
    logic [BUS-1:0]  opa_q;
    logic [BUS-1:0]  opb_q;
    logic [BUS-1:0]  str_q;
    logic [BUS-1:0]  pc_q;
    logic [BUS-1:0]  rk_q;

    // A register still owed a writeback; with bypass the
    // writeback in flight this cycle already satisfies it.
    function automatic logic pend_hit(
        input logic [3:0]      idx,
        input logic [NREG-1:0] pend,
        input logic            we,
        input logic [3:0]      wa
    );
        logic hit;
        hit = reg_ok(idx, NREG) && pend[idx];
`ifdef WB_BYPASS_EN
        if (we && wa == idx) begin
            hit = 1'b0;
        end
`endif
        return hit;
    endfunction

    always_comb begin
        hazard = pend_hit(ra, pending, bus.WE, bus.RDwb);
        if (!immsel) begin
            hazard = hazard | pend_hit(rb, pending, bus.WE, bus.RDwb);
        end
        if (is_store) begin
            hazard = hazard | pend_hit(rd, pending, bus.WE, bus.RDwb);
        end
    end

    assign ready  = rst & ~hazard & ~bus.flush & (~vld | bus.out_ready);
    assign accept = bus.in_valid & ready;

    // Clears first so that a same-cycle new claim wins.
    always_comb begin
        pend_nxt = pending;
        if (bus.WE && reg_ok(bus.RDwb, NREG)) begin
            pend_nxt[bus.RDwb] = 1'b0;
        end
        if (bus.flush && vld && held.sel_wb && reg_ok(held.rd, NREG)) begin
            pend_nxt[held.rd] = 1'b0;
        end
        if (accept && dec.sel_wb && reg_ok(rd, NREG)) begin
            pend_nxt[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
            vld     <= 1'b0;
            held    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            str_q   <= '0;
            pc_q    <= '0;
            rk_q    <= '0;
        end else begin
            pending <= pend_nxt;
            if (bus.flush) begin
                vld <= 1'b0;
            end else if (accept) begin
                vld   <= 1'b1;
                held  <= dec;
                opa_q <= rf_a;
                opb_q <= immsel ? imm_sx : rf_b;
                str_q <= is_store ? rf_s : '0;
                pc_q  <= bus.PCi;
                rk_q  <= imm_sx;
            end else if (bus.out_ready) begin
                vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = vld;
    assign bus.OPA        = opa_q;
    assign bus.OPB        = opb_q;
    assign bus.STR_DATA   = str_q;
    assign bus.PCo        = pc_q;
    assign bus.RKo        = rk_q;
    assign bus.RDo        = held.rd;
    assign bus.FUNTYPE    = held.funtype;
    assign bus.FUNCODE    = held.funcode;
    assign bus.selWB      = held.sel_wb;
    assign bus.selMEMRD   = held.sel_memrd;
    assign bus.selMEMWR   = held.sel_memwr;
    assign bus.selCACHEWR = held.sel_cachewr;
    assign bus.selCACHESH = held.sel_cachesh;
    assign bus.selBRANCH  = held.sel_branch;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed vectors,
// expected bundles queued on accept, popped by a monitor.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.BUS(32)) bus ();

    id_stage_pipe #(
        .BUS  (32),
        .NREG (16),
        .IMMW (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] str;
        logic [31:0] pc;
        logic [31:0] rk;
        logic [3:0]  rd;
        logic [1:0]  ft;
        logic [1:0]  fc;
        logic [5:0]  sel;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t act();
        exp_t a;
        a.opa = bus.OPA;
        a.opb = bus.OPB;
        a.str = bus.STR_DATA;
        a.pc  = bus.PCo;
        a.rk  = bus.RKo;
        a.rd  = bus.RDo;
        a.ft  = bus.FUNTYPE;
        a.fc  = bus.FUNCODE;
        a.sel = {bus.selWB, bus.selMEMRD, bus.selMEMWR,
                 bus.selCACHEWR, bus.selCACHESH, bus.selBRANCH};
        return a;
    endfunction

    function automatic exp_t E(input int opa, input int opb,
                               input int str, input int pc,
                               input int rk, input int rd,
                               input int ft, input int fc,
                               input int sel);
        exp_t e;
        e.opa = opa;
        e.opb = opb;
        e.str = str;
        e.pc  = pc;
        e.rk  = rk;
        e.rd  = rd[3:0];
        e.ft  = ft[1:0];
        e.fc  = fc[1:0];
        e.sel = sel[5:0];
        return e;
    endfunction

    function automatic logic [31:0] mk(input int ft, input int fc,
                                       input int rd, input int ra,
                                       input int rb, input int is,
                                       input int imm);
        logic [31:0] v;
        v = {ft[1:0], fc[1:0], rd[3:0], ra[3:0], rb[3:0],
             is[0], imm[14:0]};
        return v;
    endfunction

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    task automatic chkv(input string n, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input exp_t e, input bit push,
                        output int waited);
        logic r;
        r = 1'b0;
        waited = 0;
        bus.instruction = ins;
        bus.PCi = pc;
        bus.in_valid = 1'b1;
        while (!r && waited < 40) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            if (r) begin
                if (push) q.push_back(e);
            end else begin
                waited++;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        if (!r) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout pc=%h actual=stalled required=accept", pc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle actual=%h required=none", act());
                end else begin
                    e = q.pop_front();
                    chkv($sformatf("bundle_pc_%0h", e.pc), act(), e);
                end
            end
        end
    end

    initial begin
        int w;
        logic r;
        exp_t e2;
        exp_t ea;

        bus.instruction = '0;
        bus.PCi = '0;
        bus.in_valid = 1'b0;
        bus.WBd = '0;
        bus.RDwb = '0;
        bus.WE = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chkv("rst_outputs", act(), '0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("idle_in_ready", bus.in_ready, 1'b1);
        tick();

        // 1: write R8=3, ADD r1 <- r8 + r3
        bus.WE = 1'b1;
        bus.RDwb = 4'd8;
        bus.WBd = 32'd3;
        tick();
        bus.WE = 1'b0;
        send(mk(0, 0, 1, 8, 3, 0, 0), 32'h100,
             E(3, 0, 0, 'h100, 0, 1, 0, 0, 'b100000), 1, w);
        @(negedge clk);
        chk1("t1_latency", bus.out_valid, 1'b1);
        tick();

        // 2: load r2, dependent ADD r4 <- r2 + 5
        send(mk(1, 0, 2, 0, 0, 1, 0), 32'h104,
             E(0, 0, 0, 'h104, 0, 2, 1, 0, 'b110000), 1, w);
        e2 = E(7, 5, 0, 'h108, 5, 4, 0, 0, 'b100000);
        bus.instruction = mk(0, 0, 4, 2, 0, 1, 5);
        bus.PCi = 32'h108;
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("t2_raw_stall", bus.in_ready, 1'b0);
            tick();
        end
        bus.WE = 1'b1;
        bus.RDwb = 4'd2;
        bus.WBd = 32'd7;
        @(negedge clk);
        r = bus.in_ready;
        chk1("t2_wb_cycle_ready", r, BYP);
        @(posedge clk);
        if (r) q.push_back(e2);
        #1;
        bus.WE = 1'b0;
        if (!r) begin
            @(negedge clk);
            r = bus.in_ready;
            chk1("t2_after_wb_ready", r, 1'b1);
            @(posedge clk);
            if (r) q.push_back(e2);
            #1;
        end
        bus.in_valid = 1'b0;
        tick();

        // 3: backpressure with a second instruction waiting
        bus.out_ready = 1'b0;
        ea = E(3, 16, 0, 'h10C, 16, 9, 0, 1, 'b100000);
        send(mk(0, 1, 9, 8, 0, 1, 'h10), 32'h10C, ea, 1, w);
        bus.instruction = mk(3, 0, 0, 8, 8, 0, 0);
        bus.PCi = 32'h110;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("t3_in_ready_low", bus.in_ready, 1'b0);
            chk1("t3_valid_held", bus.out_valid, 1'b1);
            chkv("t3_bundle_stable", act(), ea);
            tick();
        end
        bus.out_ready = 1'b1;
        send(mk(3, 0, 0, 8, 8, 0, 0), 32'h110,
             E(3, 3, 0, 'h110, 0, 0, 3, 0, 'b000100), 1, w);
        chki("t3_issue_on_ready", w, 0);

        // 4: immediate sign extension
        send(mk(2, 0, 0, 0, 0, 1, 'h7FFF), 32'h114,
             E(0, 'hFFFFFFFF, 0, 'h114, 'hFFFFFFFF, 0, 2, 0, 'b000001),
             1, w);
        tick();

        // 5: flush a held load r5, then read r5 without stall
        bus.out_ready = 1'b0;
        send(mk(1, 0, 5, 0, 0, 1, 0), 32'h118, '0, 0, w);
        bus.flush = 1'b1;
        @(negedge clk);
        chk1("t5_flush_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk1("t5_flushed_valid", bus.out_valid, 1'b0);
        tick();
        bus.out_ready = 1'b1;
        send(mk(0, 0, 10, 5, 0, 1, 1), 32'h11C,
             E(0, 1, 0, 'h11C, 1, 10, 0, 0, 'b100000), 1, w);
        chki("t5_no_stall", w, 0);
        tick();

        // 6: store, cache share, unlisted funcode
        bus.WE = 1'b1;
        bus.RDwb = 4'd6;
        bus.WBd = 32'hA5;
        tick();
        bus.WE = 1'b0;
        send(mk(1, 1, 6, 8, 0, 1, 4), 32'h120,
             E(3, 4, 'hA5, 'h120, 4, 6, 1, 1, 'b001000), 1, w);
        send(mk(0, 0, 11, 6, 0, 1, 0), 32'h124,
             E('hA5, 0, 0, 'h124, 0, 11, 0, 0, 'b100000), 1, w);
        chki("t6_store_no_pending", w, 0);
        send(mk(3, 1, 12, 0, 0, 1, 2), 32'h128,
             E(0, 2, 0, 'h128, 2, 12, 3, 1, 'b000010), 1, w);
        send(mk(1, 3, 0, 0, 0, 1, 0), 32'h12C,
             E(0, 0, 0, 'h12C, 0, 0, 1, 3, 'b000000), 1, w);
        tick();

        // reset while a bundle is held under backpressure
        bus.out_ready = 1'b0;
        send(mk(0, 0, 13, 0, 0, 1, 3), 32'h130, '0, 0, w);
        @(negedge clk);
        chk1("t6_held_before_rst", bus.out_valid, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("t6_rst_valid", bus.out_valid, 1'b0);
        chkv("t6_rst_outputs", act(), '0);
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        send(mk(0, 0, 14, 1, 8, 0, 0), 32'h134,
             E(0, 0, 0, 'h134, 0, 14, 0, 0, 'b100000), 1, w);
        chki("t6_rst_clears_pending", w, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chki("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle instruction decoder.
- Decodes one instruction per cycle and reads operands from an internal register file with a writeback port.
- Tracks pending destination writes in a scoreboard, stalls on read-after-write hazards, and registers the decoded bundle into a one-deep ID/EX output stage with valid/ready handshakes.
- Sits between the fetch stage and the execute stage.

Parameters:
- BUS, 32: data/PC width.
- NREG, 16: architectural registers, 2..16; register index fields are 4 bits, and indices >= NREG read 0 and never write.
- IMMW, 15: immediate field width, sign-extended to BUS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- instruction  in  32  instruction word
- PCi  in  BUS  PC of instruction
- in_valid  in  1  upstream holds valid instruction
- in_ready  out  1  stage accepts instruction this cycle
- WBd  in  BUS  writeback data
- RDwb  in  4  writeback register
- WE  in  1  writeback enable
- flush  in  1  kill instruction held in output stage
- out_ready  in  1  execute accepts bundle
- out_valid  out  1  bundle valid
- OPA, OPB, STR_DATA, PCo, RKo  out  BUS  operand A, operand B (register or immediate), store data, PC, sign-extended immediate
- RDo  out  4  destination register
- FUNTYPE, FUNCODE  out  2 each  operation class/code
- selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH  out  1 each  control selects

Behaviour:
- Reset (rst=0 at posedge): all outputs 0, register file all 0, scoreboard clear, out_valid=0. Reset mid-transfer discards the held bundle.
- Instruction fields:
  - [31:30] FUNTYPE, [29:28] FUNCODE, [27:24] RD, [23:20] RA, [19:16] RB, [15] IMMSEL, [14:0] IMM.
- Control decode:
  - FUNTYPE 00 ALU: selWB=1.
  - FUNTYPE 01 memory: FUNCODE 00 load (selMEMRD=1, selWB=1); FUNCODE 01 store (selMEMWR=1, STR_DATA=R[RD]).
  - FUNTYPE 10 branch: selBRANCH=1.
  - FUNTYPE 11 cache: FUNCODE 00 selCACHEWR=1, FUNCODE 01 selCACHESH=1.
  - Unlisted FUNCODEs: all selects 0.
- Operands: OPA=R[RA]; OPB=IMMSEL ? sext(IMM) : R[RB]. R0 reads 0 and is never pending.
- Register file: write on WE at posedge, except RDwb=0.
- Uses: RA always; RB when !IMMSEL; RD for stores.
- Scoreboard pending[NREG]:
  - Set pending[RD] on accept of a selWB instruction.
  - Clear pending[RDwb] on WE.
  - Same register set and cleared in one cycle: set wins.
- hazard = any used source pending (subject to bypass, see Optional Feature).
- in_ready = rst & !hazard & !flush & (!out_valid | out_ready).
- Accept (in_valid & in_ready): bundle registered next edge; latency 1 cycle; out_valid=1.
- Output stage: bundle and out_valid hold stable while out_valid & !out_ready. out_valid drops after out_ready unless a new accept occurs in the same cycle, giving back-to-back throughput of 1 per cycle.
- flush:
  - out_valid=0 next edge.
  - If the held bundle had selWB, clear pending[RDo], unless a WE to the same register sets nothing; clear applies.
  - No accept in the flush cycle.

Optional Feature:
- WB_BYPASS_EN defined: a source matching RDwb with WE=1 reads WBd in the same cycle and is not counted as a hazard, so a dependent instruction issues in the writeback cycle.
- Undefined: operand reads return the pre-write value, and pending stays set until the edge, giving one extra stall cycle after writeback.

Decomposition:
- Package id_pkg: field position constants, FUNTYPE/FUNCODE enums, typedef decoded_t (struct of all output fields).
- Sub-module id_regfile: 2 read ports + store-data read port, 1 write port, optional bypass.
- Decode and scoreboard live in the top module.

Test Plan:
1. Reset then WE=1, RDwb=8, WBd=3; next cycle send ADD r1<-r8+r3 (IMMSEL=0), R3=0 -> after 1 cycle out_valid=1, OPA=3, OPB=0, RDo=1, FUNTYPE=00, selWB=1.
2. RAW hazard: issue load r2 (pending[2]=1), then ADD r4<-r2+imm5 -> in_ready=0 until WE RDwb=2 WBd=7. With WB_BYPASS_EN: issue in WE cycle, OPA=7. Without: issue next cycle.
3. Backpressure: out_ready=0 for 3 cycles with two instructions queued -> bundle stable, in_ready=0, second issued in the cycle out_ready rises.
4. Immediate sign extension: IMMSEL=1, IMM=15'h7FFF -> OPB=RKo=32'hFFFFFFFF.
5. Flush of held load r5 -> out_valid=0 next cycle, pending[5]=0, and a dependent reader of r5 issues without a stall.
6. Store FUNTYPE=01 FUNCODE=01 RD=6 with R6=0xA5 -> STR_DATA=0xA5, selMEMWR=1, selWB=0, no pending set; reset mid-backpressure clears out_valid.
